// File: rtl/fetchbuf_pkg.sv
// Shared types for the fetch buffer: ITIM bus structs, queue entry, control state.
package fetchbuf_wires;

   typedef struct packed {
      logic        mem_valid;
      logic        mem_fence;
      logic        mem_instr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic [31:0] mem_rdata;
      logic        mem_ready;
   } mem_out_type;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetchbuf_entry_type;

   typedef enum logic [1:0] {
      run    = 2'd0,
      fdrain = 2'd1,
      fwait  = 2'd2
   } fetchbuf_state_type;

   typedef struct packed {
      fetchbuf_state_type state;
      logic [31:0]        pc;
      logic               outstanding;
      logic               discard;
      logic [31:0]        counter;
   } fetchbuf_reg_type;

   localparam fetchbuf_reg_type fetchbuf_reg_init = '{
      state:       run,
      pc:          32'h0,
      outstanding: 1'b0,
      discard:     1'b0,
      counter:     32'h0
   };

   // A window whose low two bits are 2'b11 starts a 32-bit instruction.
   function automatic logic [31:0] instr_extract(input logic [31:0] window);
      return (window[1:0] == 2'b11) ? window : {16'h0, window[15:0]};
   endfunction

   function automatic logic [31:0] instr_step(input logic [31:0] window);
      return (window[1:0] == 2'b11) ? 32'd4 : 32'd2;
   endfunction

endpackage

// File: rtl/fetchbuf_if.sv
// ITIM request/response bus as seen by the fetch buffer (master) and the ITIM (slave).
interface fetchbuf_if;
   import fetchbuf_wires::*;

   mem_in_type  imem_in;
   mem_out_type imem_out;

   modport master (output imem_in, input imem_out);
   modport slave  (input imem_in, output imem_out);
endinterface

// File: rtl/fetchbuf_fifo.sv
// Small {pc, instr} queue between fetch and decode; head is a plain register read.
module fetchbuf_fifo
   import fetchbuf_wires::*;
#(
   parameter int depth = 4
) (
   input  logic                   reset,
   input  logic                   clock,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetchbuf_entry_type     push_data,
   output fetchbuf_entry_type     head,
   output logic                   valid,
   output logic [$clog2(depth):0] count
);
   localparam int aw = $clog2(depth);
   localparam int cw = aw + 1;

   fetchbuf_entry_type slots [depth];
   logic [aw-1:0]      wptr;
   logic [aw-1:0]      rptr;

   // NOTE: storage has no reset; only pointers and count decide what is valid.
   always_ff @(posedge clock) begin
      if (push) slots[wptr] <= push_data;
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + aw'(1);
         if (pop)  rptr <= rptr + aw'(1);
         if (push && !pop)      count <= count + cw'(1);
         else if (pop && !push) count <= count - cw'(1);
      end
   end

   assign head  = slots[rptr];
   assign valid = (count != '0);

endmodule

// File: rtl/fetchbuf.sv
// Fetch request control, RV32IC length split, redirect and fence.i sequencing
// in front of the ITIM; decoded entries are queued in fetchbuf_fifo.
module fetchbuf
   import fetchbuf_wires::*;
#(
   parameter int          fetchbuf_depth = 4,
   parameter logic [31:0] boot_addr      = 32'h0,
   parameter int          itim_depth     = 4,
   parameter int          fence_wait     = itim_depth + 2
) (
   input  logic        reset,
   input  logic        clock,
   fetchbuf_if.master  imem,
   input  logic        jump_valid,
   input  logic [31:0] jump_addr,
   input  logic        fence_valid,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_instr,
   input  logic        fetch_ready
);
   localparam int cw = $clog2(fetchbuf_depth) + 1;

   fetchbuf_reg_type   r;
   fetchbuf_reg_type   rin;
   mem_in_type         mi;
   mem_out_type        mo;
   fetchbuf_entry_type push_data;
   fetchbuf_entry_type head;
   logic               push;
   logic               pop;
   logic               flush;
   logic               room;
   logic               fifo_valid;
   logic [cw-1:0]      fifo_count;

   assign mo           = imem.imem_out;
   assign imem.imem_in = mi;

   fetchbuf_fifo #(.depth(fetchbuf_depth)) fifo_0 (
      .reset     (reset),
      .clock     (clock),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .push_data (push_data),
      .head      (head),
      .valid     (fifo_valid),
      .count     (fifo_count)
   );

   assign fetch_valid = reset && (r.state == run) && fifo_valid;
   assign fetch_pc    = head.pc;
   assign fetch_instr = head.instr;
   assign pop         = fetch_valid && fetch_ready;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latches.
      rin          = r;
      mi           = '0;
      mi.mem_instr = 1'b1;
      push         = 1'b0;
      push_data    = '0;
      flush        = 1'b0;
      room         = 1'b0;

      case (r.state)
         run: begin
            if (fence_valid || jump_valid) begin
               flush  = 1'b1;
               rin.pc = jump_addr;
               room   = 1'b1;
               if (mo.mem_ready) begin
                  rin.outstanding = 1'b0;
                  rin.discard     = 1'b0;
               end else if (r.outstanding) begin
                  rin.discard = 1'b1;
               end
               if (fence_valid) rin.state = fdrain;
            end else begin
               if (mo.mem_ready) begin
                  rin.outstanding = 1'b0;
                  if (r.discard) begin
                     rin.discard = 1'b0;
                  end else begin
                     push      = 1'b1;
                     push_data = '{pc: r.pc, instr: instr_extract(mo.mem_rdata)};
                     rin.pc    = r.pc + instr_step(mo.mem_rdata);
                  end
               end
               // Only issue when the response is sure to find a free slot.
               room = (int'(fifo_count) + int'(push) - int'(pop)) < fetchbuf_depth;
            end
            if (!fence_valid && room && (!r.outstanding || mo.mem_ready)) begin
               mi.mem_valid    = 1'b1;
               mi.mem_addr     = rin.pc;
               rin.outstanding = 1'b1;
            end
         end
         fdrain: begin
            if (jump_valid) rin.pc = jump_addr;
            if (mo.mem_ready) begin
               rin.outstanding = 1'b0;
               rin.discard     = 1'b0;
            end
            if (!r.outstanding || mo.mem_ready) begin
               mi.mem_valid = 1'b1;
               mi.mem_fence = 1'b1;
               rin.counter  = 32'(fence_wait);
               rin.state    = fwait;
            end
         end
         fwait: begin
            if (jump_valid) rin.pc = jump_addr;
            if (r.counter <= 32'd1) begin
               rin.counter = '0;
               rin.state   = run;
            end else begin
               rin.counter = r.counter - 32'd1;
            end
         end
         default: rin.state = run;
      endcase

      if (!reset) begin
         mi.mem_valid = 1'b0;
         mi.mem_fence = 1'b0;
         mi.mem_addr  = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r    <= fetchbuf_reg_init;
         r.pc <= boot_addr;
      end else begin
         r <= rin;
      end
   end

endmodule

// File: tb/tb_fetchbuf.sv
// Directed bench for fetchbuf: an ITIM responder with settable latency feeds a
// scoreboard of expected {pc, instr} entries that is checked on every pop.
module tb_fetchbuf;
   import fetchbuf_wires::*;

   localparam int          depth      = 4;
   localparam logic [31:0] boot       = 32'h0;
   localparam int          fence_wait = 6;

   logic        reset;
   logic        clock;
   logic        jump_valid;
   logic [31:0] jump_addr;
   logic        fence_valid;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_instr;
   logic        fetch_ready;

   fetchbuf_if imem ();

   fetchbuf #(
      .fetchbuf_depth (depth),
      .boot_addr      (boot),
      .itim_depth     (4),
      .fence_wait     (fence_wait)
   ) dut (
      .reset       (reset),
      .clock       (clock),
      .imem        (imem.master),
      .jump_valid  (jump_valid),
      .jump_addr   (jump_addr),
      .fence_valid (fence_valid),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .fetch_instr (fetch_instr),
      .fetch_ready (fetch_ready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0]        itim_mem [logic [31:0]];
   fetchbuf_entry_type exp_q [$];
   logic               pend = 1'b0;
   logic               pend_stale = 1'b0;
   logic [31:0]        pend_addr = '0;
   int                 pend_wait = 0;
   int                 lat = 1;
   logic               obs_req;
   logic               obs_fence;
   logic [31:0]        obs_addr;
   int                 n_req;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] itim_word(input logic [31:0] a);
      if (itim_mem.exists(a)) return itim_mem[a];
      return 32'h0000_0013;
   endfunction

   function automatic logic [31:0] model_instr(input logic [31:0] w);
      return (w[1:0] == 2'b11) ? w : {16'h0, w[15:0]};
   endfunction

   // One clock cycle, entered and left at the falling edge with strobes already set.
   task automatic cycle();
      logic               resp;
      logic [31:0]        w;
      fetchbuf_entry_type e;
      resp = pend && (pend_wait == 0) && reset;
      w    = itim_word(pend_addr);
      imem.imem_out.mem_ready = resp;
      imem.imem_out.mem_rdata = resp ? w : 32'h0;
      if (resp && !pend_stale && !jump_valid && !fence_valid)
         exp_q.push_back('{pc: pend_addr, instr: model_instr(w)});
      #1;
      obs_req   = imem.imem_in.mem_valid && !imem.imem_in.mem_fence;
      obs_fence = imem.imem_in.mem_valid && imem.imem_in.mem_fence;
      obs_addr  = imem.imem_in.mem_addr;
      if (fetch_valid && fetch_ready) begin
         if (exp_q.size() == 0) begin
            check32("sb_entry_expected", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check32("pop_pc", fetch_pc, e.pc);
            check32("pop_instr", fetch_instr, e.instr);
         end
      end
      @(posedge clock);
      if (!reset) begin
         pend       = 1'b0;
         pend_stale = 1'b0;
         exp_q.delete();
      end else begin
         if (resp) pend = 1'b0;
         else if (pend && pend_wait > 0) pend_wait--;
         if (jump_valid || fence_valid) begin
            exp_q.delete();
            if (pend) pend_stale = 1'b1;
         end
         if (obs_req) begin
            pend       = 1'b1;
            pend_addr  = obs_addr;
            pend_wait  = lat - 1;
            pend_stale = 1'b0;
         end
      end
      @(negedge clock);
   endtask

   task automatic run_until_req(input string tag, input int max_cycles);
      logic found;
      found = 1'b0;
      for (int i = 0; i < max_cycles && !found; i++) begin
         cycle();
         found = obs_req;
      end
      check32(tag, 32'(found), 32'd1);
   endtask

   initial begin
      reset       = 1'b0;
      jump_valid  = 1'b0;
      jump_addr   = '0;
      fence_valid = 1'b0;
      fetch_ready = 1'b1;
      imem.imem_out = '0;
      @(negedge clock);

      // Reset values
      for (int i = 0; i < 3; i++) cycle();
      check32("rst_mem_valid", 32'(imem.imem_in.mem_valid), 32'd0);
      check32("rst_mem_fence", 32'(imem.imem_in.mem_fence), 32'd0);
      check32("rst_mem_instr", 32'(imem.imem_in.mem_instr), 32'd1);
      check32("rst_mem_addr", imem.imem_in.mem_addr, 32'h0);
      check32("rst_mem_wdata", imem.imem_in.mem_wdata, 32'h0);
      check32("rst_mem_wstrb", 32'(imem.imem_in.mem_wstrb), 32'd0);
      check32("rst_fetch_valid", 32'(fetch_valid), 32'd0);

      // Streaming 32-bit instructions, 1-cycle latency: a request every cycle
      reset = 1'b1;
      cycle();
      check32("first_req_valid", 32'(obs_req), 32'd1);
      check32("first_req_addr", obs_addr, boot);
      n_req = 0;
      for (int i = 0; i < 7; i++) begin
         cycle();
         n_req += int'(obs_req);
      end
      check32("stream_req_per_cycle", 32'(n_req), 32'd7);
      check32("stream_wstrb", 32'(imem.imem_in.mem_wstrb), 32'd0);

      // Backpressure fills the queue and stops requests
      fetch_ready = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      check32("full_entries", 32'(exp_q.size()), 32'(depth));
      n_req = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         n_req += int'(obs_req);
      end
      check32("full_no_req", 32'(n_req), 32'd0);
      check32("full_fetch_valid", 32'(fetch_valid), 32'd1);
      fetch_ready = 1'b1;
      cycle();
      check32("one_pop_one_req", 32'(obs_req), 32'd1);
      fetch_ready = 1'b0;
      n_req = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         n_req += int'(obs_req);
      end
      check32("refill_no_extra_req", 32'(n_req), 32'd0);
      check32("refill_entries", 32'(exp_q.size()), 32'(depth));

      // Jump while a slow request is outstanding
      lat = 3;
      fetch_ready = 1'b1;
      run_until_req("slow_req_issued", 4);
      jump_valid = 1'b1;
      jump_addr  = 32'h100;
      cycle();
      jump_valid = 1'b0;
      check32("jump_pending_no_req", 32'(obs_req), 32'd0);
      check32("jump_flush_valid", 32'(fetch_valid), 32'd0);
      lat = 1;
      run_until_req("jump_req_issued", 6);
      check32("jump_req_addr", obs_addr, 32'h100);
      for (int i = 0; i < 8 && !fetch_valid; i++) cycle();
      check32("jump_head_pc", fetch_pc, 32'h100);
      check32("jump_head_instr", fetch_instr, 32'h13);

      // Jump in the response cycle issues at once; pc wraps past 2^32
      cycle();
      cycle();
      jump_valid = 1'b1;
      jump_addr  = 32'hFFFF_FFFC;
      cycle();
      jump_valid = 1'b0;
      check32("jump_same_cycle_req", 32'(obs_req), 32'd1);
      check32("jump_same_cycle_addr", obs_addr, 32'hFFFF_FFFC);
      cycle();
      check32("wrap_req_addr", obs_addr, 32'h0);

      // fence.i: one fence pulse, fence_wait idle cycles, then resume at jump_addr
      cycle();
      cycle();
      fence_valid = 1'b1;
      jump_addr   = 32'h200;
      cycle();
      fence_valid = 1'b0;
      check32("fence_cycle_no_req", 32'(obs_req), 32'd0);
      cycle();
      check32("fence_pulse", 32'(obs_fence), 32'd1);
      check32("fence_addr", obs_addr, 32'h0);
      n_req = 0;
      for (int i = 0; i < fence_wait; i++) begin
         cycle();
         n_req += int'(obs_req) + int'(obs_fence);
         if (i == 2) check32("fwait_fetch_valid", 32'(fetch_valid), 32'd0);
      end
      check32("fwait_idle", 32'(n_req), 32'd0);
      cycle();
      check32("resume_req", 32'(obs_req), 32'd1);
      check32("resume_addr", obs_addr, 32'h200);

      // Reset with a request outstanding; compressed instruction at boot
      itim_mem[32'h0] = 32'h4501_4501;
      for (int i = 0; i < 3; i++) cycle();
      lat = 3;
      run_until_req("pre_reset_req", 4);
      cycle();
      reset = 1'b0;
      cycle();
      cycle();
      check32("mid_rst_mem_valid", 32'(imem.imem_in.mem_valid), 32'd0);
      check32("mid_rst_fetch_valid", 32'(fetch_valid), 32'd0);
      reset = 1'b1;
      lat   = 1;
      cycle();
      check32("reboot_req", 32'(obs_req), 32'd1);
      check32("reboot_addr", obs_addr, boot);
      cycle();
      check32("rvc_next_addr", obs_addr, 32'h2);
      check32("rvc_head_valid", 32'(fetch_valid), 32'd1);
      check32("rvc_head_pc", fetch_pc, 32'h0);
      check32("rvc_head_instr", fetch_instr, 32'h0000_4501);
      for (int i = 0; i < 6; i++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
